// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stage registers.
// Occupancy state encoding, the bubble value and the default bundle widths per boundary.
package pipe_pkg;

    // The encoding doubles as the entry count: 0, 1 or 2 entries held.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    localparam int IDEX_CTRL_W  = 11;
    localparam int IDEX_DATA_W  = 143;
    localparam int EXMEM_CTRL_W = 4;
    localparam int EXMEM_DATA_W = 106;
    localparam int MEMWB_CTRL_W = 2;
    localparam int MEMWB_DATA_W = 69;

    // Replicated to CTRL_W bits; an all-zero control bundle carries no write enables.
    localparam logic BUBBLE_BIT = 1'b0;

    function automatic logic is_full(input state_t s);
        return s == ST_TWO;
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline slot: a valid bit plus the concatenated control/data payload.
// Payload loads only on load; valid sets on load and drops on clear.
module pipe_entry_reg #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         valid
);

    // NOTE: the payload is reset too, so out_data is never X after reset, even though
    // its value is don't-care while the slot is invalid.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            q     <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every flop samples pre-edge values.
            if (clear)
                valid <= 1'b0;
            else if (load)
                valid <= 1'b1;
            if (load)
                q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready stage register for the ID/EX, EX/MEM and MEM/WB boundaries,
// with an optional 2-entry skid (SKID=1) and a synchronous flush.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int CTRL_W = IDEX_CTRL_W,
    parameter int DATA_W = IDEX_DATA_W,
    parameter bit SKID   = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    localparam int W = CTRL_W + DATA_W;

    state_t         state, state_nxt;
    logic           accept, drain;
    logic           main_valid, skid_valid;
    logic           main_load, main_clear;
    logic [W-1:0]   main_q, skid_q, main_d;

    assign accept = in_valid & in_ready;
    assign drain  = main_valid & out_ready;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (accept) state_nxt = ST_ONE;
            ST_ONE: begin
                if (accept && !drain)
                    state_nxt = ST_TWO;
                else if (!accept && drain)
                    state_nxt = ST_EMPTY;
            end
            ST_TWO:   if (drain) state_nxt = ST_ONE;
            default:  state_nxt = ST_EMPTY;
        endcase
        if (flush)
            state_nxt = ST_EMPTY;
    end

    // Main refills from the skid when draining TWO, otherwise from the input.
    always_comb begin
        main_d     = (state == ST_TWO) ? skid_q : {in_ctrl, in_data};
        main_load  = 1'b0;
        main_clear = flush;
        if (!flush) begin
            if (state == ST_TWO)
                main_load = drain;
            else
                main_load = accept && (state == ST_EMPTY || drain);
            main_clear = (state == ST_ONE) && drain && !accept;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= ST_EMPTY;
        else
            state <= state_nxt;
    end

    pipe_entry_reg #(.W(W)) u_main (
        .clock (clock),
        .reset (reset),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .q     (main_q),
        .valid (main_valid)
    );

    generate
        if (SKID) begin : g_skid
            logic in_ready_q;

            // Registered from the next state, so in_ready never sees out_ready combinationally.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset)
                    in_ready_q <= 1'b1;
                else
                    in_ready_q <= !is_full(state_nxt);
            end
            assign in_ready = in_ready_q;

            pipe_entry_reg #(.W(W)) u_skid (
                .clock (clock),
                .reset (reset),
                .load  (!flush && (state == ST_ONE) && accept && !drain),
                .clear (flush || ((state == ST_TWO) && drain)),
                .d     ({in_ctrl, in_data}),
                .q     (skid_q),
                .valid (skid_valid)
            );
        end else begin : g_noskid
            assign in_ready   = !main_valid | out_ready;
            assign skid_q     = '0;
            assign skid_valid = 1'b0;
        end
    endgenerate

    assign out_valid = main_valid;
    assign out_ctrl  = main_valid ? main_q[W-1:DATA_W] : {CTRL_W{BUBBLE_BIT}};
    assign out_data  = main_q[DATA_W-1:0];
    assign occupancy = {skid_valid, main_valid & ~skid_valid};

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: a SKID=1 and a SKID=0 instance share one stimulus stream,
// each compared against a bounded-FIFO reference model.
module tb_pipe_stage_elastic;

    localparam int CW = 11;
    localparam int DW = 143;
    typedef logic [CW+DW-1:0] item_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          flush = 1'b0;
    logic          out_ready = 1'b0;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;

    logic          rdy1, ov1, rdy0, ov0;
    logic [CW-1:0] oc1, oc0;
    logic [DW-1:0] od1, od0;
    logic [1:0]    occ1, occ0;

    int total = 0;
    int bad   = 0;

    item_t q1[$];
    item_t q0[$];

    always #5 clock = ~clock;

    pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1)) dut_skid (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(ov1),
        .out_ready(out_ready), .out_ctrl(oc1), .out_data(od1), .occupancy(occ1)
    );

    pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0)) dut_noskid (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(ov0),
        .out_ready(out_ready), .out_ctrl(oc0), .out_data(od0), .occupancy(occ0)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare both DUTs against the reference queues; inputs for this cycle already applied.
    task automatic check_model();
        item_t h;
        check("skid.out_valid", 256'(ov1), 256'(q1.size() > 0));
        check("skid.occupancy", 256'(occ1), 256'(q1.size()));
        check("skid.in_ready", 256'(rdy1), 256'(q1.size() < 2));
        if (q1.size() > 0) begin
            h = q1[0];
            check("skid.out_ctrl", 256'(oc1), 256'(h[CW+DW-1:DW]));
            check("skid.out_data", 256'(od1), 256'(h[DW-1:0]));
        end else begin
            check("skid.bubble_ctrl", 256'(oc1), 256'(0));
        end
        check("noskid.out_valid", 256'(ov0), 256'(q0.size() > 0));
        check("noskid.occupancy", 256'(occ0), 256'(q0.size()));
        check("noskid.in_ready", 256'(rdy0), 256'((q0.size() == 0) || out_ready));
        if (q0.size() > 0) begin
            h = q0[0];
            check("noskid.out_ctrl", 256'(oc0), 256'(h[CW+DW-1:DW]));
            check("noskid.out_data", 256'(od0), 256'(h[DW-1:0]));
        end else begin
            check("noskid.bubble_ctrl", 256'(oc0), 256'(0));
        end
    endtask

    task automatic step(input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                        input logic ordy, input logic fl);
        logic a1, d1, a0, d0;
        @(negedge clock);
        in_valid  = iv;
        in_ctrl   = ic;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #1;
        check_model();
        a1 = iv && (q1.size() < 2);
        d1 = (q1.size() > 0) && ordy;
        a0 = iv && ((q0.size() == 0) || ordy);
        d0 = (q0.size() > 0) && ordy;
        if (fl) begin
            q1.delete();
            q0.delete();
        end else begin
            if (d1) q1.delete(0);
            if (a1) q1.push_back({ic, id});
            if (d0) q0.delete(0);
            if (a0) q0.push_back({ic, id});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".skid.out_valid"}, 256'(ov1), 256'(0));
        check({tag, ".skid.out_ctrl"}, 256'(oc1), 256'(0));
        check({tag, ".skid.out_data"}, 256'(od1), 256'(0));
        check({tag, ".skid.occupancy"}, 256'(occ1), 256'(0));
        check({tag, ".skid.in_ready"}, 256'(rdy1), 256'(1));
        check({tag, ".noskid.out_valid"}, 256'(ov0), 256'(0));
        check({tag, ".noskid.out_ctrl"}, 256'(oc0), 256'(0));
        check({tag, ".noskid.occupancy"}, 256'(occ0), 256'(0));
        check({tag, ".noskid.in_ready"}, 256'(rdy0), 256'(1));
    endtask

    initial begin
        // Reset held with a valid input pending: nothing may be captured.
        reset     = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = '1;
        in_data   = '1;
        out_ready = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("reset");
        in_valid = 1'b0;
        reset    = 1'b1;

        // Streaming at full rate.
        for (int i = 0; i < 8; i++)
            step(1'b1, 11'(i), 143'(32 * i), 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // Stall after A with B arriving, then release.
        step(1'b1, 11'h0A1, 143'h1111, 1'b1, 1'b0);
        step(1'b1, 11'h0B2, 143'h2222, 1'b0, 1'b0);
        step(1'b1, 11'h0C3, 143'h3333, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // Flush with both entries full and a valid input in the same cycle.
        step(1'b1, 11'h1C1, 143'h4444, 1'b1, 1'b0);
        step(1'b1, 11'h1D2, 143'h5555, 1'b0, 1'b0);
        step(1'b1, 11'h1E3, 143'h6666, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b1);
        step(1'b1, 11'h1F4, 143'h7777, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a stall, between clock edges.
        step(1'b1, 11'h2A1, 143'h8888, 1'b1, 1'b0);
        step(1'b1, 11'h2B2, 143'h9999, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clock);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("midreset");
        q1.delete();
        q0.delete();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;

        // Randomized traffic with occasional flushes.
        repeat (400)
            step($urandom_range(0, 3) != 0, 11'($urandom),
                 143'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()}),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        repeat (3)
            step(1'b0, '0, '0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
